// File: rtl/reg_rename_table.sv
// Logical-to-physical register rename table with two combinational lookup ports,
// SWAP/ROTATE table edits and a small checkpoint stack of whole-table snapshots.
module reg_rename_table #(
    parameter  int NUM_REGS   = 4,
    parameter  int CKPT_DEPTH = 2,
    localparam int REG_W      = $clog2(NUM_REGS),
    localparam int CNT_W      = $clog2(CKPT_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op_code,
    input  logic [REG_W-1:0] reg1,
    input  logic [REG_W-1:0] reg2,
    output logic [REG_W-1:0] reg1_mapped,
    output logic [REG_W-1:0] reg2_mapped,
    output logic [CNT_W-1:0] ckpt_count,
    output logic             ckpt_full,
    output logic             ckpt_empty,
    output logic             op_error,
    output logic             is_identity
);

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_SWAP   = 3'd1;
    localparam logic [2:0] OP_ROTATE = 3'd2;
    localparam logic [2:0] OP_PUSH   = 3'd3;
    localparam logic [2:0] OP_POP    = 3'd4;

    localparam int SP_W = (CKPT_DEPTH > 1) ? $clog2(CKPT_DEPTH) : 1;

    // Handshake: op_valid qualifies op_code/reg1/reg2 for exactly one cycle. There is
    // no ready; every valid op is consumed at the next edge, and a rejected one leaves
    // all state untouched and raises op_error for the following cycle.

    logic [REG_W-1:0] tbl       [NUM_REGS];
    logic [REG_W-1:0] tbl_nxt   [NUM_REGS];
    logic [REG_W-1:0] stack     [CKPT_DEPTH][NUM_REGS];
    logic [CNT_W-1:0] count_nxt;
    logic             err_nxt;
    logic             ident_nxt;
    logic             push_en;
    logic [SP_W-1:0]  push_idx;
    logic [SP_W-1:0]  pop_idx;
    logic [NUM_REGS-1:0] seen;
    logic             perm_ok;

    assign reg1_mapped = tbl[reg1];
    assign reg2_mapped = tbl[reg2];
    assign ckpt_full   = (ckpt_count == CNT_W'(CKPT_DEPTH));
    assign ckpt_empty  = (ckpt_count == '0);
    assign push_idx    = SP_W'(ckpt_count);
    assign pop_idx     = SP_W'(ckpt_count - CNT_W'(1));

    always_comb begin
        tbl_nxt   = tbl;
        count_nxt = ckpt_count;
        err_nxt   = 1'b0;
        push_en   = 1'b0;
        if (op_valid) begin
            case (op_code)
                OP_NOP: ;
                OP_SWAP: begin
                    tbl_nxt[reg1] = tbl[reg2];
                    tbl_nxt[reg2] = tbl[reg1];
                end
                OP_ROTATE: begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        tbl_nxt[REG_W'(i)] = tbl[REG_W'(i + 1)];
                    end
                end
                OP_PUSH: begin
                    if (!ckpt_full) begin
                        push_en   = 1'b1;
                        count_nxt = ckpt_count + CNT_W'(1);
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                OP_POP: begin
                    if (!ckpt_empty) begin
                        tbl_nxt   = stack[pop_idx];
                        count_nxt = ckpt_count - CNT_W'(1);
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                default: err_nxt = 1'b1;
            endcase
        end
    end

    // Identity flag is derived from the next table so it lines up with the registered table.
    always_comb begin
        ident_nxt = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (tbl_nxt[REG_W'(i)] != REG_W'(i)) begin
                ident_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                tbl[REG_W'(i)] <= REG_W'(i);
            end
            ckpt_count  <= '0;
            op_error    <= 1'b0;
            is_identity <= 1'b1;
        end else begin
            tbl         <= tbl_nxt;
            ckpt_count  <= count_nxt;
            op_error    <= err_nxt;
            is_identity <= ident_nxt;
        end
    end

    // Snapshot storage carries no reset; only entries below ckpt_count are meaningful.
    always_ff @(posedge clk) begin
        if (reset && push_en) begin
            stack[push_idx] <= tbl;
        end
    end

    always_comb begin
        seen = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            seen[tbl[REG_W'(i)]] = 1'b1;
        end
        perm_ok = &seen;
    end

    a_table_is_permutation: assert property (@(posedge clk) disable iff (!reset) perm_ok);
    a_count_in_range: assert property (@(posedge clk) disable iff (!reset)
                                       ckpt_count <= CNT_W'(CKPT_DEPTH));

endmodule

// File: tb/tb_reg_rename_table.sv
// Bench for reg_rename_table: a 4-entry and an 8-entry instance share one op stream and
// are compared every cycle against an array/stack reference model via expected queues.
module tb_reg_rename_table;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       op_valid;
    logic [2:0] op_code;
    logic [2:0] r1;
    logic [2:0] r2;

    logic [1:0] m1_4, m2_4, cnt_4;
    logic       full_4, empty_4, err_4, id_4;
    logic [2:0] m1_8, m2_8;
    logic [1:0] cnt_8;
    logic       full_8, empty_8, err_8, id_8;

    reg_rename_table #(.NUM_REGS(4), .CKPT_DEPTH(2)) dut4 (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
        .reg1(r1[1:0]), .reg2(r2[1:0]),
        .reg1_mapped(m1_4), .reg2_mapped(m2_4), .ckpt_count(cnt_4),
        .ckpt_full(full_4), .ckpt_empty(empty_4), .op_error(err_4), .is_identity(id_4)
    );

    reg_rename_table #(.NUM_REGS(8), .CKPT_DEPTH(3)) dut8 (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
        .reg1(r1), .reg2(r2),
        .reg1_mapped(m1_8), .reg2_mapped(m2_8), .ckpt_count(cnt_8),
        .ckpt_full(full_8), .ckpt_empty(empty_8), .op_error(err_8), .is_identity(id_8)
    );

    // ---------------- reference model (index 0: 4 regs, index 1: 8 regs) ----------------
    int          mn[2] = '{4, 8};
    int          md[2] = '{2, 3};
    int          mt[2][8];
    int          mc[2];
    bit          merr[2];
    bit          mid[2];
    logic [31:0] mstk[2][4];

    int errors = 0;
    int checks = 0;

    logic [15:0] exp4_q[$];
    logic [15:0] exp8_q[$];

    function automatic logic [31:0] pack_tbl(int k);
        logic [31:0] s = '0;
        for (int i = 0; i < 8; i++) s[i*4 +: 4] = 4'(mt[k][i]);
        return s;
    endfunction

    // Record layout: [15:12] m1, [11:8] m2, [7:6] count, 5 full, 4 empty, 3 err, 2 ident.
    function automatic logic [15:0] expect_rec(int k, int a, int b);
        int n = mn[k];
        return {4'(mt[k][a % n]), 4'(mt[k][b % n]), 2'(mc[k]),
                mc[k] == md[k], mc[k] == 0, merr[k], mid[k], 2'b00};
    endfunction

    task automatic model_step(int k, bit rst, bit v, int op, int a, int b);
        int n = mn[k];
        int tmp[8];
        int t;
        logic [31:0] s;
        a = a % n;
        b = b % n;
        if (!rst) begin
            for (int i = 0; i < 8; i++) mt[k][i] = i;
            mc[k] = 0;
            merr[k] = 1'b0;
            mid[k] = 1'b1;
            return;
        end
        merr[k] = 1'b0;
        if (v) begin
            case (op)
                0: ;
                1: begin
                    t = mt[k][a];
                    mt[k][a] = mt[k][b];
                    mt[k][b] = t;
                end
                2: begin
                    for (int i = 0; i < n; i++) tmp[i] = mt[k][(i + 1) % n];
                    for (int i = 0; i < n; i++) mt[k][i] = tmp[i];
                end
                3: begin
                    if (mc[k] < md[k]) begin
                        mstk[k][mc[k]] = pack_tbl(k);
                        mc[k]++;
                    end else merr[k] = 1'b1;
                end
                4: begin
                    if (mc[k] > 0) begin
                        mc[k]--;
                        s = mstk[k][mc[k]];
                        for (int i = 0; i < 8; i++) mt[k][i] = int'(s[i*4 +: 4]);
                    end else merr[k] = 1'b1;
                end
                default: merr[k] = 1'b1;
            endcase
        end
        mid[k] = 1'b1;
        for (int i = 0; i < n; i++) if (mt[k][i] != i) mid[k] = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_field(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_rec(string tag, logic [15:0] e, logic [15:0] a);
        check_field({tag, ".reg1_mapped"}, int'(a[15:12]), int'(e[15:12]));
        check_field({tag, ".reg2_mapped"}, int'(a[11:8]),  int'(e[11:8]));
        check_field({tag, ".ckpt_count"},  int'(a[7:6]),   int'(e[7:6]));
        check_field({tag, ".ckpt_full"},   int'(a[5]),     int'(e[5]));
        check_field({tag, ".ckpt_empty"},  int'(a[4]),     int'(e[4]));
        check_field({tag, ".op_error"},    int'(a[3]),     int'(e[3]));
        check_field({tag, ".is_identity"}, int'(a[2]),     int'(e[2]));
    endtask

    always @(negedge clk) begin
        if (exp4_q.size() > 0) begin
            check_rec("n4", exp4_q.pop_front(),
                      {2'b00, m1_4, 2'b00, m2_4, cnt_4, full_4, empty_4, err_4, id_4, 2'b00});
        end
        if (exp8_q.size() > 0) begin
            check_rec("n8", exp8_q.pop_front(),
                      {1'b0, m1_8, 1'b0, m2_8, cnt_8, full_8, empty_8, err_8, id_8, 2'b00});
        end
    end

    // ---------------- driver ----------------
    task automatic step(bit rst, bit v, int op, int a, int b);
        reset    = rst;
        op_valid = v;
        op_code  = 3'(op);
        r1       = 3'(a);
        r2       = 3'(b);
        exp4_q.push_back(expect_rec(0, a, b));
        exp8_q.push_back(expect_rec(1, a, b));
        model_step(0, rst, v, op, a, b);
        model_step(1, rst, v, op, a, b);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sel;
        int op;
        bit v;
        bit rst;
        reset    = 1'b0;
        op_valid = 1'b0;
        op_code  = 3'd0;
        r1       = 3'd0;
        r2       = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        model_step(0, 1'b0, 1'b0, 0, 0, 0);
        model_step(1, 1'b0, 1'b0, 0, 0, 0);

        // reset state lookups
        step(1, 0, 0, 2, 3);
        // swap 0<->3, observe, swap back
        step(1, 1, 1, 0, 3);
        step(1, 0, 0, 0, 3);
        step(1, 0, 0, 3, 0);
        step(1, 1, 1, 0, 3);
        step(1, 0, 0, 0, 1);
        // four rotates return to identity on the 4-entry table
        for (int i = 0; i < 4; i++) step(1, 1, 2, i, 3 - i);
        step(1, 0, 0, 1, 2);
        // push, swap, pop restores the snapshot
        step(1, 1, 3, 0, 0);
        step(1, 1, 1, 1, 2);
        step(1, 0, 0, 1, 2);
        step(1, 1, 4, 1, 2);
        step(1, 0, 0, 1, 2);
        // overflow and underflow of the checkpoint stack
        step(1, 1, 1, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 1, 3, 0, 1);
        step(1, 1, 1, 2, 3);
        for (int i = 0; i < 5; i++) step(1, 1, 4, 0, 1);
        step(1, 0, 0, 0, 1);
        // reset overrides a swap; illegal codes back to back
        step(1, 1, 1, 0, 3);
        step(0, 1, 1, 0, 3);
        step(1, 1, 6, 0, 1);
        step(1, 1, 5, 2, 3);
        step(1, 1, 7, 2, 3);
        step(1, 0, 0, 2, 3);

        // random soak
        repeat (600) begin
            rst = ($urandom_range(0, 99) >= 2);
            v   = ($urandom_range(0, 9) != 0);
            sel = $urandom_range(0, 15);
            if (sel < 6)       op = 1;
            else if (sel < 9)  op = 2;
            else if (sel < 12) op = 3;
            else if (sel < 15) op = 4;
            else               op = ($urandom_range(0, 1) != 0) ? $urandom_range(5, 7) : 0;
            step(rst, v, op, $urandom_range(0, 7), $urandom_range(0, 7));
        end

        step(1, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check_field("drain_n4", exp4_q.size(), 0);
        check_field("drain_n8", exp8_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_rename_table.md
Name: reg_rename_table

Overview:
- Parametrised successor to the 4-entry register mapper.
- Holds a logical-to-physical register permutation table of NUM_REGS entries.
- Serves two combinational lookup ports and applies one table operation per cycle: SWAP, ROTATE, CHECKPOINT PUSH or CHECKPOINT POP.
- Sits between instruction decode and the register file; the decoded register fields pass through it before reaching the register file.

Parameters:
NUM_REGS, 4, number of logical/physical registers; power of 2, minimum 2.
REG_W, $clog2(NUM_REGS), index width; derived, not overridden.
CKPT_DEPTH, 2, number of table snapshots the checkpoint stack holds; minimum 1.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
op_valid  input  1  an operation is present this cycle.
op_code  input  3  0=NOP, 1=SWAP, 2=ROTATE, 3=PUSH, 4=POP; 5-7 are illegal.
reg1  input  REG_W  lookup index A; also SWAP operand A.
reg2  input  REG_W  lookup index B; also SWAP operand B.
reg1_mapped  output  REG_W  table[reg1], combinational.
reg2_mapped  output  REG_W  table[reg2], combinational.
ckpt_count  output  $clog2(CKPT_DEPTH+1)  number of valid snapshots, registered.
ckpt_full  output  1  ckpt_count == CKPT_DEPTH.
ckpt_empty  output  1  ckpt_count == 0.
op_error  output  1  registered one-cycle pulse flagging a rejected operation.
is_identity  output  1  registered; 1 when table[i]==i for all i.

Behaviour:
- Reset (reset==0 at a clk edge):
  - table[i] <= i.
  - ckpt_count <= 0.
  - op_error <= 0.
  - is_identity <= 1.
  - Stack contents are don't-care.
  - Reset overrides any op_valid in the same cycle; reset mid-sequence discards all snapshots.
- Lookups:
  - reg1_mapped and reg2_mapped are purely combinational from the current table, i.e. the value before this cycle's operation.
  - An update becomes visible in the cycle after the edge that applied it. There is no write-through bypass.
- Ops apply only when op_valid==1 and reset==1. At most one op per cycle.
- NOP, or op_valid==0: table and stack hold; op_error <= 0.
- SWAP: table[reg1] <= table[reg2] and table[reg2] <= table[reg1], simultaneously. reg1==reg2 leaves the table unchanged and is not an error.
- ROTATE: table[i] <= table[(i+1) mod NUM_REGS] for all i. Rotating NUM_REGS times restores the original table.
- PUSH:
  - If !ckpt_full: stack[ckpt_count] <= table and ckpt_count++. The table is unchanged.
  - If full: no state change; op_error <= 1.
- POP:
  - If !ckpt_empty: table <= stack[ckpt_count-1] and ckpt_count--.
  - If empty: no state change; op_error <= 1.
- Illegal op_code (5-7) with op_valid: no state change; op_error <= 1.
- op_error:
  - Asserted for exactly the one cycle following the rejected op.
  - Cleared on the next edge unless another op is rejected.
  - Back-to-back rejected ops hold it high.
- ckpt_full and ckpt_empty are decoded from the registered ckpt_count, so they are valid the cycle after each PUSH or POP.
- is_identity is computed from the next-state table and registered, so it is aligned with the table it describes.
- Invariant: the table is a permutation of 0..NUM_REGS-1 at all times. SVA must check this every cycle out of reset.

Test Plan:
1. Reset, NUM_REGS=4 -> reg1=2 gives reg1_mapped=2, reg2=3 gives reg2_mapped=3; ckpt_empty=1; is_identity=1; op_error=0.
2. SWAP reg1=0, reg2=3 -> same cycle reg1_mapped=0; next cycle reg1=0 gives 3 and reg1=3 gives 0; is_identity=0. A second identical SWAP restores identity.
3. ROTATE from identity -> table={1,2,3,0}. Three further ROTATEs -> identity with is_identity=1.
4. PUSH, then SWAP 1<->2, then POP -> table returns to its pre-swap value; ckpt_count goes 0,1,1,0.
5. CKPT_DEPTH=2: three PUSHes -> third gives op_error=1 for one cycle with ckpt_count=2. POP x3 -> third gives op_error=1 with the table unchanged.
6. SWAP issued together with reset=0, then op_code=6 -> first: table is identity, op ignored. Second: op_error=1 one cycle, table unchanged. Repeat with NUM_REGS=8 for a random-permutation soak, with the permutation assertion active.
